// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache: 8 blocks of 4 x 32-bit words.
// A hit returns in the same cycle; a miss fetches one whole block from memory.
module icache_ctrl (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  ADDRESS,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic [5:0]   MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);

    typedef enum logic [1:0] {StIdle, StFetch, StUpdate} state_e;

    state_e       state_q, state_d;
    logic [7:0]   valid_q, valid_d;
    logic [2:0]   miss_tag_q, miss_tag_d;
    logic [2:0]   miss_idx_q, miss_idx_d;
    logic [2:0]   tag_q  [8];
    logic [127:0] data_q [8];

    logic [1:0]   offset;
    logic [2:0]   index;
    logic [2:0]   tag;
    logic         hit;
    logic         fill_en;
    logic         unused_addr;

    assign offset      = ADDRESS[3:2];
    assign index       = ADDRESS[6:4];
    assign tag         = ADDRESS[9:7];
    assign unused_addr = ^{ADDRESS[31:10], ADDRESS[1:0]};

    assign hit     = valid_q[index] && (tag_q[index] == tag);
    assign fill_en = (state_q == StFetch) && !MEM_BUSYWAIT;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= StIdle;
            valid_q    <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
        end
    end

    // Tag and data arrays are deliberately not reset; the valid bits gate them.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            data_q[miss_idx_q] <= MEM_READDATA;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        miss_tag_d = miss_tag_q;
        miss_idx_d = miss_idx_q;
        unique case (state_q)
            StIdle: begin
                if (!hit) begin
                    state_d    = StFetch;
                    miss_tag_d = tag;
                    miss_idx_d = index;
                end
            end
            StFetch: begin
                if (!MEM_BUSYWAIT) begin
                    state_d             = StUpdate;
                    valid_d[miss_idx_q] = 1'b1;
                end
            end
            StUpdate: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        INSTRUCTION = '0;
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b0;
        MEM_ADDRESS = '0;
        unique case (state_q)
            StIdle: begin
                BUSYWAIT = !hit;
                if (hit) begin
                    INSTRUCTION = data_q[index][{offset, 5'b00000} +: 32];
                end
            end
            StFetch: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {miss_tag_q, miss_idx_q};
            end
            StUpdate: BUSYWAIT = 1'b1;
            default:  BUSYWAIT = 1'b1;
        endcase
        // Fetch side sees a quiet, non-stalling cache while held in reset.
        if (!RESET) begin
            BUSYWAIT    = 1'b0;
            INSTRUCTION = '0;
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: stimulus queues expected responses, a monitor
// pops and checks them whenever the cache stops stalling.
module tb_icache_ctrl;

    logic         CLK = 1'b1;
    logic         RESET = 1'b1;
    logic [31:0]  ADDRESS = '0;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    icache_ctrl dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ADDRESS      (ADDRESS),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word(input logic [5:0] b, input int w);
        logic [31:0] wv;
        wv = w;
        return 32'hC0DE_0000 | {18'd0, b, 8'd0} | {30'd0, wv[1:0]};
    endfunction

    function automatic logic [127:0] blk(input logic [5:0] b);
        return {word(b, 3), word(b, 2), word(b, 1), word(b, 0)};
    endfunction

    // Memory model: block valid on the lat-th consecutive MEM_READ cycle.
    int lat = 5;
    int mem_cnt = 0;
    always @(posedge CLK) mem_cnt <= MEM_READ ? mem_cnt + 1 : 0;
    assign MEM_BUSYWAIT = !(MEM_READ && (mem_cnt == lat - 1));
    assign MEM_READDATA = MEM_BUSYWAIT ? {4{32'hDEAD_BEEF}} : blk(MEM_ADDRESS);

    typedef struct {
        logic [31:0] instr;
        int          stall;
        int          rd;
        logic [5:0]  ma;
    } exp_t;

    exp_t exp_q[$];
    int   req_id  = 0;
    int   done_id = 0;
    int   checks  = 0;
    int   fails   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    initial begin
        int         stall = 0;
        int         rd = 0;
        logic [5:0] first_ma = '0;
        logic       ma_moved = 1'b0;
        exp_t       e;
        forever begin
            @(negedge CLK or negedge RESET);
            if (CLK) begin
                // Reset edge away from the clock: memory request must drop at once.
                #1 check("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
            end else begin
                if (!MEM_READ) check("idle_mem_addr", {26'd0, MEM_ADDRESS}, 32'd0);
                if (req_id != done_id) begin
                    if (BUSYWAIT) begin
                        stall++;
                        if (MEM_READ) begin
                            rd++;
                            if (rd == 1) first_ma = MEM_ADDRESS;
                            else if (MEM_ADDRESS != first_ma) ma_moved = 1'b1;
                        end
                    end else if (exp_q.size() == 0) begin
                        check("queue_empty", 32'd1, 32'd0);
                        done_id++;
                    end else begin
                        e = exp_q.pop_front();
                        check("instruction", INSTRUCTION, e.instr);
                        check("stall_cycles", stall, e.stall);
                        check("mem_read_cycles", rd, e.rd);
                        if (e.rd > 0) begin
                            check("mem_address", {26'd0, first_ma}, {26'd0, e.ma});
                            check("mem_address_stable", {31'd0, ma_moved}, 32'd0);
                        end
                        stall    = 0;
                        rd       = 0;
                        ma_moved = 1'b0;
                        done_id++;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input logic [31:0] instr, input int stall,
                         input int rd, input logic [5:0] ma);
        exp_t e;
        e.instr = instr;
        e.stall = stall;
        e.rd    = rd;
        e.ma    = ma;
        ADDRESS = addr;
        exp_q.push_back(e);
        req_id++;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_id != req_id && n < 100) begin
            @(posedge CLK);
            n++;
        end
        if (done_id != req_id) begin
            $display("FAIL timeout: request %0d never completed, done %0d", req_id, done_id);
            $fatal(1, "bench timeout");
        end
        #1;
    endtask

    task automatic access(input logic [31:0] addr, input logic [31:0] instr, input int stall,
                          input int rd, input logic [5:0] ma);
        issue(addr, instr, stall, rd, ma);
        wait_done();
    endtask

    initial begin
        #1 RESET = 1'b0;
        access(32'h0, 32'd0, 0, 0, 6'd0);
        RESET = 1'b1;

        // Cold miss with 5-cycle memory, then sequential hits.
        access(32'h0000_0000, word(6'd0, 0), 7, 5, 6'd0);
        access(32'h0000_0004, word(6'd0, 1), 0, 0, 6'd0);
        access(32'h0000_0008, word(6'd0, 2), 0, 0, 6'd0);
        access(32'h0000_000C, word(6'd0, 3), 0, 0, 6'd0);

        // Conflict on index 1.
        access(32'h0000_0010, word(6'd1, 0), 7, 5, 6'd1);
        lat = 2;
        access(32'h0000_0090, word(6'd9, 0), 4, 2, 6'b001001);
        lat = 5;
        access(32'h0000_0014, word(6'd1, 1), 7, 5, 6'd1);

        // ADDRESS wanders during the fill; the latched miss address wins.
        issue(32'h0000_0020, word(6'd2, 0), 7, 5, 6'd2);
        @(posedge CLK);
        @(posedge CLK);
        #1 ADDRESS = 32'h0000_0040;
        @(posedge CLK);
        #1 ADDRESS = 32'h0000_0020;
        wait_done();
        access(32'h0000_0024, word(6'd2, 1), 0, 0, 6'd0);
        access(32'h0000_0040, word(6'd4, 0), 7, 5, 6'd4);

        // Upper and byte-offset bits alias onto block 0.
        access(32'h0000_0400, word(6'd0, 0), 0, 0, 6'd0);
        access(32'hFFFF_FC0E, word(6'd0, 3), 0, 0, 6'd0);

        // Reset in the third FETCH cycle of a miss to 0x0A0.
        issue(32'h0000_00A0, 32'd0, 3, 2, 6'b001010);
        @(posedge CLK);
        @(posedge CLK);
        @(posedge CLK);
        #1 RESET = 1'b0;
        wait_done();
        RESET = 1'b1;
        access(32'h0000_0020, word(6'd2, 0), 7, 5, 6'd2);
        lat = 1;
        access(32'h0000_0000, word(6'd0, 0), 3, 1, 6'd0);
        access(32'h0000_0008, word(6'd0, 2), 0, 0, 6'd0);

        repeat (2) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
